// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 key controller: frame FSM states,
// prefix and scan codes, direction encodings and the queued event record.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } frame_state_e;

  localparam logic [7:0] CODE_E0 = 8'hE0;
  localparam logic [7:0] CODE_F0 = 8'hF0;

  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_SPACE = 8'h29;

  localparam logic [4:0] DIR_UP     = 5'b00010;
  localparam logic [4:0] DIR_LEFT   = 5'b00100;
  localparam logic [4:0] DIR_DOWN   = 5'b01000;
  localparam logic [4:0] DIR_RIGHT  = 5'b10000;
  localparam logic [4:0] DIR_ACTION = 5'b00111;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } ps2_event_t;

  localparam int EVENT_W = $bits(ps2_event_t);

  // Arrow keys and WASD share a direction; unknown codes keep the last one.
  function automatic logic [4:0] next_direcao(input logic [7:0] code, input logic [4:0] cur);
    case (code)
      SC_UP,    SC_W: next_direcao = DIR_UP;
      SC_LEFT,  SC_A: next_direcao = DIR_LEFT;
      SC_DOWN,  SC_S: next_direcao = DIR_DOWN;
      SC_RIGHT, SC_D: next_direcao = DIR_RIGHT;
      SC_SPACE:       next_direcao = DIR_ACTION;
      default:        next_direcao = cur;
    endcase
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Small event FIFO with combinational head; a push into a full FIFO is
// accepted only when a pop happens in the same cycle, else it is dropped.
module ps2_event_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_ready,
  output logic             valid,
  output logic [WIDTH-1:0] head,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             full, pop, accept;

  assign valid    = (count_q != '0);
  assign head     = valid ? mem_q[rd_ptr_q] : '0;
  assign overflow = overflow_q;

  always_comb begin
    full       = (count_q == CW'(DEPTH));
    pop        = valid && pop_ready;
    accept     = push && (!full || pop);
    wr_ptr_d   = accept ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q;
    if (accept && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!accept && pop) begin
      count_d = count_q - 1'b1;
    end
    overflow_d = push && !accept;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage carries no reset so it can map onto distributed/block RAM.
  always_ff @(posedge clock) begin
    if (accept) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/ps2_key_controller.sv
// PS/2 keyboard receiver: synchronizes the bus, frames bytes, folds E0/F0
// prefixes into key events and queues them. Optional PS2_TIMEOUT_EN drops stale frames.
module ps2_key_controller
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_break,
  output logic [4:0] direcao,
  output logic       frame_err,
  output logic       overflow
);

  logic [1:0]   clk_sync_q, clk_sync_d;
  logic [1:0]   data_sync_q, data_sync_d;
  logic         clk_prev_q, clk_prev_d;
  frame_state_e state_q, state_d;
  logic [2:0]   bit_cnt_q, bit_cnt_d;
  logic [7:0]   shift_q, shift_d;
  logic         parity_q, parity_d;
  logic         ext_q, ext_d;
  logic         brk_q, brk_d;
  logic         push_q, push_d;
  ps2_event_t   push_ev_q, push_ev_d;
  logic         frame_err_q, frame_err_d;
  logic [4:0]   direcao_q, direcao_d;
  logic         fall, data_bit, timeout;
  logic [EVENT_W-1:0] head;
  ps2_event_t   head_ev;

  assign fall     = clk_prev_q && !clk_sync_q[1];
  assign data_bit = data_sync_q[1];

`ifdef PS2_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  assign timeout   = !fall && (state_q != ST_IDLE) && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES));
  assign tmo_cnt_d = (fall || state_q == ST_IDLE) ? '0 : tmo_cnt_q + 1'b1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) tmo_cnt_q <= '0;
    else       tmo_cnt_q <= tmo_cnt_d;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout            = 1'b0;
`endif

  always_comb begin
    clk_sync_d  = {clk_sync_q[0], ps2_clk};
    data_sync_d = {data_sync_q[0], ps2_data};
    clk_prev_d  = clk_sync_q[1];
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    ext_d       = ext_q;
    brk_d       = brk_q;
    push_d      = 1'b0;
    push_ev_d   = push_ev_q;
    frame_err_d = 1'b0;
    direcao_d   = direcao_q;

    // Direction follows releases as they are offered to the FIFO, even if dropped.
    if (push_q && push_ev_q.brk) begin
      direcao_d = next_direcao(push_ev_q.code, direcao_q);
    end

    if (timeout) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      ext_d     = 1'b0;
      brk_d     = 1'b0;
    end else if (fall) begin
      case (state_q)
        ST_IDLE: begin
          if (!data_bit) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end else begin
            frame_err_d = 1'b1;
          end
        end
        ST_DATA: begin
          shift_d   = {data_bit, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          parity_d = data_bit;
          state_d  = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if ((^{shift_q, parity_q}) && data_bit) begin
            if (shift_q == CODE_E0) begin
              ext_d = 1'b1;
            end else if (shift_q == CODE_F0) begin
              brk_d = 1'b1;
            end else begin
              push_d    = 1'b1;
              push_ev_d = '{code: shift_q, ext: ext_q, brk: brk_q};
              ext_d     = 1'b0;
              brk_d     = 1'b0;
            end
          end else begin
            frame_err_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      push_q      <= 1'b0;
      push_ev_q   <= '0;
      frame_err_q <= 1'b0;
      direcao_q   <= '0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_prev_q  <= clk_prev_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      push_q      <= push_d;
      push_ev_q   <= push_ev_d;
      frame_err_q <= frame_err_d;
      direcao_q   <= direcao_d;
    end
  end

  ps2_event_fifo #(
    .WIDTH(EVENT_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push_q),
    .push_data(push_ev_q),
    .pop_ready(ev_ready),
    .valid    (ev_valid),
    .head     (head),
    .overflow (overflow)
  );

  assign head_ev   = head;
  assign ev_code   = head_ev.code;
  assign ev_ext    = head_ev.ext;
  assign ev_break  = head_ev.brk;
  assign direcao   = direcao_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_key_controller.sv
// Randomized scoreboard bench for ps2_key_controller; build with +define+PS2_TIMEOUT_EN
// to also exercise the partial-frame timeout.
module tb_ps2_key_controller;

  localparam int TO    = 100;
  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       ev_ready;
  logic       ev_valid;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_break;
  logic [4:0] direcao;
  logic       frame_err;
  logic       overflow;

  ps2_key_controller #(.TIMEOUT_CYCLES(TO), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code), .ev_ext(ev_ext),
    .ev_break(ev_break), .direcao(direcao), .frame_err(frame_err), .overflow(overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit [7:0] code;
    bit       ext;
    bit       brk;
  } ev_t;

  ev_t      exp_q[$];
  int       checks = 0;
  int       errors = 0;
  int       err_pulses = 0;
  int       ovf_pulses = 0;
  int       exp_err = 0;
  int       exp_ovf = 0;
  int       lat_seen = -1;
  int       ready_mode = 0;  // 0: hold low, 1: random, 2: always high
  bit       m_ext = 0;
  bit       m_brk = 0;
  bit [4:0] m_dir = 0;
  bit [4:0] dir_map [bit [7:0]];

  initial begin
    ev_ready = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      case (ready_mode)
        1:       ev_ready = 1'($urandom_range(0, 1));
        2:       ev_ready = 1'b1;
        default: ev_ready = 1'b0;
      endcase
    end
  end

  // Monitor: every accepted head event is checked against the scoreboard.
  always @(negedge clock) begin
    if (!reset) begin
      if (frame_err) err_pulses++;
      if (overflow)  ovf_pulses++;
      if (ev_valid && ev_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL event: unexpected code=%02h ext=%0d brk=%0d, none required",
                   ev_code, ev_ext, ev_break);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          if (ev_code !== e.code || ev_ext !== e.ext || ev_break !== e.brk) begin
            errors++;
            $display("FAIL event: got code=%02h ext=%0d brk=%0d, required code=%02h ext=%0d brk=%0d",
                     ev_code, ev_ext, ev_break, e.code, e.ext, e.brk);
          end else begin
            $display("event ok: code=%02h ext=%0d brk=%0d", ev_code, ev_ext, ev_break);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  // One PS/2 bit cell: data set up, clock low 8 cycles, clock high.
  task automatic ps2_bit(input bit b, input bit measure);
    ps2_data = b;
    repeat (4) tick();
    ps2_clk = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (measure && ev_valid && lat_seen < 0) lat_seen = k;
    end
    ps2_clk = 1'b1;
    repeat (4) tick();
  endtask

  // Reference behaviour of one received byte, applied before it is sent.
  task automatic model_byte(input bit [7:0] b, input bit good, input bit drop);
    if (!good) begin
      exp_err++;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else begin
      ev_t e;
      e.code = b; e.ext = m_ext; e.brk = m_brk;
      if (drop) exp_ovf++;
      else      exp_q.push_back(e);
      if (m_brk && dir_map.exists(b)) m_dir = dir_map[b];
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  task automatic check_after(input bit [7:0] b);
    $display("frame %02h: direcao=%05b errs=%0d ovf=%0d", b, direcao, err_pulses, ovf_pulses);
    chk("direcao", int'(direcao), int'(m_dir));
    chk("frame_err_count", err_pulses, exp_err);
    chk("overflow_count", ovf_pulses, exp_ovf);
  endtask

  task automatic send_byte(input bit [7:0] b, input bit bad_par, input bit bad_stop,
                           input bit drop, input bit measure);
    bit par;
    model_byte(b, !bad_par && !bad_stop, drop);
    par = (~^b) ^ bad_par;
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], 1'b0);
    ps2_bit(par, 1'b0);
    ps2_bit(~bad_stop, measure);
    ps2_data = 1'b1;
    repeat (12) tick();
    check_after(b);
  endtask

  task automatic wait_drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 400) begin
      tick();
      k++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_ev_valid", int'(ev_valid), 0);
    chk("rst_ev_code", int'(ev_code), 0);
    chk("rst_ev_ext", int'(ev_ext), 0);
    chk("rst_ev_break", int'(ev_break), 0);
    chk("rst_direcao", int'(direcao), 0);
    chk("rst_frame_err", int'(frame_err), 0);
    chk("rst_overflow", int'(overflow), 0);
  endtask

  initial begin
    bit [7:0] pool [11];
    pool = '{8'hE0, 8'hF0, 8'h75, 8'h1D, 8'h6B, 8'h1C, 8'h72, 8'h1B, 8'h74, 8'h23, 8'h29};
    dir_map[8'h75] = 5'b00010; dir_map[8'h1D] = 5'b00010;
    dir_map[8'h6B] = 5'b00100; dir_map[8'h1C] = 5'b00100;
    dir_map[8'h72] = 5'b01000; dir_map[8'h1B] = 5'b01000;
    dir_map[8'h74] = 5'b10000; dir_map[8'h23] = 5'b10000;
    dir_map[8'h29] = 5'b00111;

    repeat (3) tick();
    chk_reset_outputs();
    reset = 1'b0;
    repeat (4) tick();

    // Make then break of the same key.
    ready_mode = 1;
    send_byte(8'h1D, 0, 0, 0, 0);
    send_byte(8'hF0, 0, 0, 0, 0);
    send_byte(8'h1D, 0, 0, 0, 0);
    chk("dir_after_1D_break", int'(direcao), 5'b00010);

    // Extended release and push latency from the synced stop edge.
    wait_drain();
    ready_mode = 0;
    send_byte(8'hE0, 0, 0, 0, 0);
    send_byte(8'hF0, 0, 0, 0, 0);
    lat_seen = -1;
    send_byte(8'h75, 0, 0, 0, 1);
    chk("latency_raw_edge_to_valid", lat_seen, 4);
    ready_mode = 1;
    wait_drain();

    // Parity error leaves the prefix state alone.
    send_byte(8'h29, 1, 0, 0, 0);
    send_byte(8'hF0, 0, 0, 0, 0);
    send_byte(8'h29, 0, 0, 0, 0);
    chk("dir_action", int'(direcao), 5'b00111);

    // Fill with consumer stalled; the fifth event is dropped.
    wait_drain();
    ready_mode = 0;
    begin
      bit [7:0] mk [5];
      mk = '{8'h15, 8'h24, 8'h2D, 8'h2C, 8'h3C};
      for (int i = 0; i < 5; i++) send_byte(mk[i], 0, 0, exp_q.size() >= DEPTH, 0);
    end
    chk("held_events", int'(ev_valid), 1);
    ready_mode = 2;
    wait_drain();
    ready_mode = 1;

`ifdef PS2_TIMEOUT_EN
    // Stalled partial frame after an E0 prefix is abandoned silently.
    send_byte(8'hE0, 0, 0, 0, 0);
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'($urandom_range(0, 1)), 1'b0);
    repeat (150) tick();
    m_ext = 0;
    m_brk = 0;
    send_byte(8'hF0, 0, 0, 0, 0);
    send_byte(8'h6B, 0, 0, 0, 0);
    chk("dir_after_timeout", int'(direcao), 5'b00100);
    wait_drain();
`endif

    // Randomized traffic with occasional corrupted frames and start glitches.
    for (int n = 0; n < 40; n++) begin
      int kind;
      bit [7:0] b;
      kind = int'($urandom_range(0, 15));
      b = (kind == 15) ? 8'($urandom_range(0, 255)) : pool[$urandom_range(0, 10)];
      if (kind == 0) begin
        exp_err++;
        ps2_bit(1'b1, 1'b0);
        repeat (12) tick();
        check_after(8'h00);
      end else begin
        send_byte(b, kind == 1 || kind == 2, kind == 3, 0, 0);
      end
    end
    wait_drain();

    // Reset in the middle of a frame.
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_bit(1'b0, 1'b0);
    reset = 1'b1;
    tick();
    tick();
    chk_reset_outputs();
    m_dir = 0;
    m_ext = 0;
    m_brk = 0;
    reset = 1'b0;
    repeat (3) tick();
    send_byte(8'h72, 0, 0, 0, 0);
    wait_drain();
    chk("final_overflow_count", ovf_pulses, exp_ovf);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
